cell_bist_sequencer: RTL and testbench
======================================

Name: cell_bist_sequencer

Overview:
- Hardware stimulus/response engine for exhaustively checking a 4-input standard cell (e.g. OR4_X1) in silicon or in gate-level simulation.
- Drives every input vector 0000..1111 onto the cell under test and waits a programmable settle time per vector.
- Samples the cell output, assembles a 16-bit truth-table signature and compares it with an expected table.
- Reports pass/fail plus the first failing vector.

Parameters:
- N_IN, 4, number of cell inputs; vector count is 2**N_IN.
- SETTLE_CYCLES, 2, cycles each vector is held before the sample cycle; legal range 1..255.
- EXPECTED, 16'hFFFE, expected truth table; bit k is the required output for input vector k (default = OR4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled in IDLE only; begins a run.
- resp_in  input  1  cell-under-test output (ZN).
- vec_out  output  N_IN  drives cell inputs; bit N_IN-1 = A1 (MSB), bit 0 = A4.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  result of the last completed run; held until the next start.
- signature  output  2**N_IN  captured truth table; bit k = resp_in sampled for vector k.
- fail_valid  output  1  sticky; set on the first mismatch of the run.
- fail_index  output  N_IN  vector index of the first mismatch; valid when fail_valid=1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- Reset (rst_n=0, immediate, any state): state=IDLE; vec_out, busy, done, pass, signature, fail_valid and fail_index all 0; internal idx and cnt are 0.
- States are IDLE, SETTLE and SAMPLE. All outputs are registered.
- IDLE:
  - vec_out=0, busy=0.
  - On an edge with start=1: go to SETTLE; idx=0, cnt=0, vec_out=0, busy=1; clear signature, fail_valid, fail_index and pass.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1: go to SAMPLE on the next edge.
  - The vector is therefore held exactly SETTLE_CYCLES+1 cycles in total.
- SAMPLE, at the exiting edge:
  - signature[idx] <= resp_in.
  - If resp_in != EXPECTED[idx] and fail_valid==0: fail_valid<=1, fail_index<=idx.
  - If idx < 2**N_IN-1: idx+1, vec_out<=idx+1, cnt=0, go to SETTLE.
  - Else: go to IDLE; busy<=0; done<=1 for one cycle; vec_out<=0; pass<=1 only if no mismatch occurred, including the current sample.
- Timing for a start accepted at edge t0, with S=SETTLE_CYCLES:
  - Vector k is applied at edge t0+k(S+1).
  - Vector k is sampled at edge t0+(k+1)(S+1).
  - done is asserted at edge t0+16(S+1), i.e. t0+48 for S=2.
- resp_in is sampled only at SAMPLE edges. Glitches during SETTLE have no effect.
- start while busy is ignored; no restart and no queueing.
- start held high continuously gives back-to-back runs, each separated by one IDLE cycle.
- Reset mid-run aborts the run: no done pulse, and all outputs return to reset values.

Test Plan:
1. Ideal OR4 model, S=2, start pulse:
   - vec_out steps 0..15, each value held 3 cycles.
   - done at t0+48; signature=16'hFFFE, pass=1, fail_valid=0, busy low after done.
2. resp_in stuck at 1 -> signature=16'hFFFF, pass=0, fail_valid=1, fail_index=0.
3. AND4 model substituted -> signature=16'h8000, pass=0, fail_valid=1, fail_index=1 (first mismatch only, later mismatches do not overwrite).
4. Second start pulse at t0+10:
   - It is ignored and done still occurs at t0+48.
   - A start issued after done clears signature/fail, and the new run completes 48 cycles later.
5. rst_n driven low asynchronously while vec_out=7:
   - Outputs go to 0 immediately with no done pulse.
   - A fresh start then produces a full correct run with signature=16'hFFFE.
6. Glitch model (resp_in inverted on the first cycle of each vector, correct otherwise) -> pass=1, signature=16'hFFFE.

Source files
------------

// File: rtl/cell_bist_sequencer.sv
// Exhaustive truth-table BIST for an N_IN-input cell; a run takes 2**N_IN*(SETTLE_CYCLES+1) cycles start-to-done.
// No backpressure: start is honoured only in IDLE, results held until the next accepted start.
module cell_bist_sequencer #(
    parameter int                  N_IN          = 4,
    parameter int                  SETTLE_CYCLES = 2,
    parameter logic [2**N_IN-1:0]  EXPECTED      = 16'hFFFE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 resp_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   signature,
    output logic                 fail_valid,
    output logic [N_IN-1:0]      fail_index
);

    localparam int              NV       = 2**N_IN;
    localparam logic [7:0]      CNT_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [N_IN-1:0]   r_idx, w_idx_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [N_IN-1:0]   r_vec, w_vec_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_pass, w_pass_nxt;
    logic [NV-1:0]     r_sig, w_sig_nxt;
    logic              r_fail_vld, w_fail_vld_nxt;
    logic [N_IN-1:0]   r_fail_idx, w_fail_idx_nxt;
    logic              w_mismatch;

    assign w_mismatch = (resp_in != EXPECTED[r_idx]);

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_vec_nxt      = r_vec;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_pass_nxt     = r_pass;
        w_sig_nxt      = r_sig;
        w_fail_vld_nxt = r_fail_vld;
        w_fail_idx_nxt = r_fail_idx;

        case (r_state)
            ST_IDLE: begin
                w_vec_nxt  = '0;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt    = ST_SETTLE;
                    w_idx_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_busy_nxt     = 1'b1;
                    w_pass_nxt     = 1'b0;
                    w_sig_nxt      = '0;
                    w_fail_vld_nxt = 1'b0;
                    w_fail_idx_nxt = '0;
                end
            end
            ST_SETTLE: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (r_cnt == CNT_LAST)
                    w_state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                w_sig_nxt[r_idx] = resp_in;
                // Only the first mismatch of a run is recorded.
                if (w_mismatch && !r_fail_vld) begin
                    w_fail_vld_nxt = 1'b1;
                    w_fail_idx_nxt = r_idx;
                end
                w_cnt_nxt = '0;
                if (r_idx != IDX_LAST) begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_vec_nxt   = r_idx + 1'b1;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_vec_nxt   = '0;
                    w_pass_nxt  = !(r_fail_vld || w_mismatch);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_vec      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_sig      <= '0;
            r_fail_vld <= 1'b0;
            r_fail_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_vec      <= w_vec_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_sig      <= w_sig_nxt;
            r_fail_vld <= w_fail_vld_nxt;
            r_fail_idx <= w_fail_idx_nxt;
        end
    end

    assign vec_out    = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign signature  = r_sig;
    assign fail_valid = r_fail_vld;
    assign fail_index = r_fail_idx;

endmodule

// File: tb/tb_cell_bist_sequencer.sv
// Directed bench for cell_bist_sequencer: behavioural cell models drive resp_in, a scoreboard
// holds the expected result of each accepted run until its done pulse.
module tb_cell_bist_sequencer;

    localparam logic [15:0] EXP_TT = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        resp_in;
    logic [3:0]  vec_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic        fail_valid;
    logic [3:0]  fail_index;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    logic [3:0] vec_prev;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        logic        fv;
        logic [3:0]  fi;
    } exp_t;
    exp_t sb[$];

    cell_bist_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_in(resp_in),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .fail_valid(fail_valid), .fail_index(fail_index)
    );

    always #5 clk = ~clk;

    // Modes: 0 ideal OR4, 1 stuck-at-1, 2 AND4, 3 OR4 with a glitch just after each vector change.
    function automatic logic cell_model(input int m, input logic [3:0] v);
        case (m)
            1:       return 1'b1;
            2:       return &v;
            default: return |v;
        endcase
    endfunction

    always @(negedge clk) vec_prev <= vec_out;
    assign resp_in = cell_model(mode, vec_out) ^ ((mode == 3) && (vec_out != vec_prev));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int m);
        exp_t e;
        e.sig = '0; e.fv = 1'b0; e.fi = '0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] v;
            v = 4'(k);
            e.sig[k] = cell_model(m, v);
            if (e.sig[k] != EXP_TT[k] && !e.fv) begin
                e.fv = 1'b1;
                e.fi = v;
            end
        end
        e.pass = !e.fv;
        sb.push_back(e);
    endtask

    // Called #1 after an edge; returns #1 after the edge following done.
    task automatic run(input int m, input bit extra_start);
        int cyc;
        exp_t e;
        mode = m;
        push_exp(m);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        chk("clr_signature", 32'(signature), 32'h0);
        chk("clr_fail_valid", 32'(fail_valid), 32'h0);
        chk("clr_pass", 32'(pass), 32'h0);
        chk("busy_run", 32'(busy), 32'h1);
        while (done !== 1'b1 && cyc < 200) begin
            if (cyc < 48) chk("vec_step", 32'(vec_out), 32'(cyc / 3));
            start = (extra_start && cyc == 9);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_latency", 32'(cyc), 32'd48);
        e = sb.pop_front();
        chk("signature", 32'(signature), 32'(e.sig));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("fail_valid", 32'(fail_valid), 32'(e.fv));
        chk("fail_index", 32'(fail_index), 32'(e.fi));
        chk("busy_end", 32'(busy), 32'h0);
        chk("vec_end", 32'(vec_out), 32'h0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vec"}, 32'(vec_out), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pass"}, 32'(pass), 32'h0);
        chk({tag, "_sig"}, 32'(signature), 32'h0);
        chk({tag, "_fv"}, 32'(fail_valid), 32'h0);
        chk({tag, "_fi"}, 32'(fail_index), 32'h0);
    endtask

    initial begin
        int guard;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 1'b0);
        run(1, 1'b0);
        run(2, 1'b0);
        run(0, 1'b1);
        run(0, 1'b0);

        // Abort mid-run with vector 7 on the cell.
        mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (vec_out !== 4'd7 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_vec7", 32'(vec_out), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_done_in_reset", 32'(done), 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 32'(busy), 32'h0);
        run(0, 1'b0);

        run(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
